// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy level and almost-full/almost-empty flags.
// Optional sticky overflow/underflow flags are compiled in with `define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo #(
    parameter int ADDRSIZE  = 3,
    parameter int DATASIZE  = 32,
    parameter int MEM_TYPE  = 0,
    parameter int AF_THRESH = (1 << ADDRSIZE) - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr,
    input  logic [DATASIZE-1:0] wr_data,
    output logic                wr_full,
    input  logic                rd,
    output logic [DATASIZE-1:0] rd_data,
    output logic                rd_empty,
    output logic [ADDRSIZE:0]   level,
    output logic                almost_full,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    input  logic                err_clr,
    output logic                overflow,
    output logic                underflow,
`endif
    output logic                almost_empty
);

    localparam int                DEPTH     = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_CNT = (ADDRSIZE + 1)'(DEPTH);

    logic [ADDRSIZE:0] wr_ptr;
    logic [ADDRSIZE:0] rd_ptr;
    logic [ADDRSIZE:0] ram_used;
    logic              ram_empty;
    logic              wr_acc;
    logic              pop;
    logic              fetch;
    logic              ram_rd;

    // Pointers carry an extra wrap bit, so the difference is the RAM occupancy.
    assign ram_used  = wr_ptr - rd_ptr;
    assign wr_full   = (ram_used == DEPTH_CNT);
    assign ram_empty = (wr_ptr == rd_ptr);

    assign wr_acc = wr & ~wr_full;
    assign pop    = rd & ~rd_empty;
    assign fetch  = rd_empty | rd;
    assign ram_rd = fetch & ~ram_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_empty <= 1'b1;
            level    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (ram_rd) rd_ptr <= rd_ptr + 1'b1;
            if (fetch)  rd_empty <= ram_empty;
            case ({wr_acc, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign almost_full  = (32'(level) >= AF_THRESH);
    assign almost_empty = (32'(level) <= AE_THRESH);

    // The head register doubles as the RAM output register, which keeps block RAM inference intact.
    if (MEM_TYPE == 1) begin : g_bram
        (* ram_style = "block" *) logic [DATASIZE-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (wr_acc & ~reset) mem[wr_ptr[ADDRSIZE-1:0]] <= wr_data;
            if (ram_rd)          rd_data <= mem[rd_ptr[ADDRSIZE-1:0]];
        end
    end else begin : g_dram
        (* ram_style = "distributed" *) logic [DATASIZE-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (wr_acc & ~reset) mem[wr_ptr[ADDRSIZE-1:0]] <= wr_data;
            if (ram_rd)          rd_data <= mem[rd_ptr[ADDRSIZE-1:0]];
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // A new error in the clearing cycle wins over err_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr & wr_full)     overflow <= 1'b1;
            else if (err_clr)     overflow <= 1'b0;
            if (rd & rd_empty)    underflow <= 1'b1;
            else if (err_clr)     underflow <= 1'b0;
        end
    end
`endif

endmodule
